// File: rtl/lfsr_rng_gen.sv
// Range-limited random number generator: Fibonacci LFSR with run-time reseed and bounded rejection sampling.
// Optional RNG_ZERO_RECOVER_EN: an all-zero LFSR reloads SEED on the next edge.
module lfsr_rng_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'h8016,
    parameter int               SEED      = 42,
    parameter int               RANGE     = 1000,
    parameter int               OFFSET    = 200,
    parameter int               OUT_W     = 11,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    // req is accepted on an edge where req && ready; valid pulses once per accepted req.
    input  logic             req,
    output logic             ready,
    output logic             valid,
    output logic [OUT_W-1:0] random_value,
    output logic [WIDTH-1:0] lfsr_state,
    output logic [1:0]       fsm_state
);

    localparam int RB = $clog2(RANGE);
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [RB:0]      RANGE_X  = (RB + 1)'(RANGE);
    localparam logic [TW-1:0]    LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] lfsr;
    logic [TW-1:0]    tries;
    logic [TW-1:0]    tries_next;
    logic [OUT_W-1:0] value_next;
    logic [RB-1:0]    cand;
    logic             cand_ok;
    logic [OUT_W-1:0] value_accept;
    logic [OUT_W-1:0] value_fallback;

    assign cand    = lfsr[RB-1:0];
    // One extra bit so a power-of-two RANGE compares correctly and never rejects.
    assign cand_ok = {1'b0, cand} < RANGE_X;
    assign value_accept   = OUT_W'(cand) + OUT_W'(OFFSET);
    assign value_fallback = OUT_W'(cand) - OUT_W'(RANGE) + OUT_W'(OFFSET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED_W;
        end else if (seed_load) begin
            lfsr <= seed_in;
`ifdef RNG_ZERO_RECOVER_EN
        end else if (lfsr == '0) begin
            lfsr <= SEED_W;
`endif
        end else if (en || state == DRAW) begin
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tries        <= '0;
            random_value <= OUT_W'(OFFSET);
        end else begin
            state        <= state_next;
            tries        <= tries_next;
            random_value <= value_next;
        end
    end

    always_comb begin
        state_next = state;
        tries_next = tries;
        value_next = random_value;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = DRAW;
                    tries_next = '0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    value_next = value_accept;
                    state_next = DONE;
                end else if (tries == LAST_TRY) begin
                    value_next = value_fallback;
                    state_next = DONE;
                end else begin
                    tries_next = tries + TW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready      = (state == IDLE);
    assign valid      = (state == DONE);
    assign lfsr_state = lfsr;
    assign fsm_state  = state;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Bench for lfsr_rng_gen: small 4-bit configuration against a table-driven model, plus a full-period
// run of a default-parameter instance. Honours RNG_ZERO_RECOVER_EN when defined.
module tb_lfsr_rng_gen;

  localparam int WIDTH     = 4;
  localparam int SEED      = 1;
  localparam int RANGE     = 10;
  localparam int OFFSET    = 0;
  localparam int OUT_W     = 4;
  localparam int MAX_TRIES = 2;
  localparam int RB        = $clog2(RANGE);
`ifdef RNG_ZERO_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             seed_load = 1'b0;
  logic [WIDTH-1:0] seed_in = '0;
  logic             req = 1'b0;
  logic             ready;
  logic             valid;
  logic [OUT_W-1:0] random_value;
  logic [WIDTH-1:0] lfsr_state;
  logic [1:0]       fsm_state;

  lfsr_rng_gen #(
    .WIDTH(WIDTH), .TAPS(4'h9), .SEED(SEED), .RANGE(RANGE),
    .OFFSET(OFFSET), .OUT_W(OUT_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .ready(ready), .valid(valid), .random_value(random_value),
    .lfsr_state(lfsr_state), .fsm_state(fsm_state)
  );

  logic        reset_def = 1'b1;
  logic        en_def = 1'b0;
  logic [15:0] seed_in_def = '0;
  logic        ready_def;
  logic        valid_def;
  logic [10:0] random_value_def;
  logic [15:0] lfsr_state_def;
  logic [1:0]  fsm_state_def;

  lfsr_rng_gen dut_def (
    .clk(clk), .reset(reset_def), .en(en_def), .seed_load(1'b0), .seed_in(seed_in_def),
    .req(1'b0), .ready(ready_def), .valid(valid_def), .random_value(random_value_def),
    .lfsr_state(lfsr_state_def), .fsm_state(fsm_state_def)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  int cyc_q[$];
  int cyc = 0;

  int order[15] = '{1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8};
  int m_lfsr  = SEED;
  int m_busy  = 0;
  int m_value = OFFSET;
  int m_pend  = OFFSET;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Successor in the documented maximal sequence; zero is a fixed point.
  function automatic int step(input int x);
    for (int i = 0; i < 15; i++)
      if (order[i] == x) return order[(i + 1) % 15];
    return 0;
  endfunction

  function automatic int draw_next(input int x);
    if (RECOVER && x == 0) return SEED;
    return step(x);
  endfunction

  // Outcome of one request whose first candidate is the LFSR value l0.
  function automatic void draw(input int l0, output int k, output int val);
    int x;
    int c;
    x = l0;
    k = 0;
    val = 0;
    for (int t = 0; t < MAX_TRIES; t++) begin
      c = x % (1 << RB);
      if (c < RANGE) begin
        k = t + 1;
        val = c + OFFSET;
        return;
      end
      if (t == MAX_TRIES - 1) begin
        k = t + 1;
        val = c - RANGE + OFFSET;
        return;
      end
      x = draw_next(x);
    end
  endfunction

  // driver: one clock edge with the currently driven inputs, model update, then output checks
  task automatic tick();
    int nxt;
    int bb;
    int k;
    int val;
    bb = m_busy;
    if (seed_load) nxt = seed_in;
    else if (RECOVER && m_lfsr == 0) nxt = SEED;
    else if (en || bb >= 2) nxt = step(m_lfsr);
    else nxt = m_lfsr;
    @(posedge clk);
    cyc++;
    if (m_busy > 0) m_busy--;
    if (bb == 2) m_value = m_pend;
    if (bb == 0 && req) begin
      draw(nxt, k, val);
      m_busy = k + 1;
      m_pend = val;
      exp_q.push_back(OUT_W'(val));
      cyc_q.push_back(cyc + k);
    end
    m_lfsr = nxt;
    #1;
    check("lfsr_state", lfsr_state, nxt);
    check("ready", ready, m_busy == 0);
    check("valid", valid, m_busy == 1);
    check("random_value_held", random_value, m_value);
  endtask

  task automatic apply_reset();
    req = 1'b0;
    seed_load = 1'b0;
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_lfsr = SEED;
    m_busy = 0;
    m_value = OFFSET;
    exp_q.delete();
    cyc_q.delete();
    check("reset_ready", ready, 1);
    check("reset_valid", valid, 0);
    check("reset_random_value", random_value, OFFSET);
    check("reset_lfsr_state", lfsr_state, SEED);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL valid_timeout: got no valid within %0d cycles, required one", bound);
    end
  endtask

  // One request: pulse req, wait for the delivery, return to IDLE.
  task automatic do_req();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_valid(MAX_TRIES + 2);
    tick();
  endtask

  // monitor: pops an expectation every time the DUT presents valid
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got valid with value %0d, required no delivery", random_value);
      end else begin
        check("delivered_value", random_value, exp_q.pop_front());
        check("delivery_cycle", cyc, cyc_q.pop_front());
      end
    end
  end

  initial begin
    int mask;
    int hits;

    apply_reset();

    // first three requests with en=0 deliver the sequence values directly
    do_req();
    check("first_value", random_value, 1);
    check("first_lfsr", lfsr_state, 3);
    do_req();
    check("second_value", random_value, 3);
    do_req();
    check("third_value", random_value, 7);
    check("third_lfsr", lfsr_state, 15);
    // 15 rejected, 14 on last try falls back to 14-10
    do_req();
    check("fallback_value", random_value, 4);
    check("fallback_lfsr", lfsr_state, 13);

    // free-run period of the 4-bit LFSR
    apply_reset();
    en = 1'b1;
    mask = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      mask |= (1 << lfsr_state);
    end
    en = 1'b0;
    check("period_states_covered", mask, 32'hFFFE);
    check("period_back_to_seed", lfsr_state, SEED);

    // reseed to zero
    seed_in = '0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("zero_loaded", lfsr_state, 0);
    tick();
`ifdef RNG_ZERO_RECOVER_EN
    check("zero_recovered", lfsr_state, SEED);
`else
    check("zero_locked", lfsr_state, 0);
    do_req();
    check("zero_lock_value", random_value, OFFSET);
    check("zero_lock_lfsr", lfsr_state, 0);
`endif

    // reset in the middle of a draw drops the pending delivery
    apply_reset();
    seed_in = 4'd15;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b1;
    tick();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      en = 1'($urandom_range(0, 1));
      req = ($urandom_range(0, 2) != 0);
      seed_load = (m_busy == 0) && ($urandom_range(0, 15) == 0);
      seed_in = WIDTH'($urandom_range(0, 15));
      tick();
    end
    req = 1'b0;
    seed_load = 1'b0;
    for (int i = 0; i < MAX_TRIES + 3; i++) tick();
    check("queue_drained", exp_q.size(), 0);

    // default-parameter instance: reset values and maximal 16-bit period
    @(negedge clk);
    check("def_reset_value", random_value_def, 200);
    check("def_reset_lfsr", lfsr_state_def, 42);
    check("def_reset_ready", ready_def, 1);
    check("def_reset_valid", valid_def, 0);
    reset_def = 1'b0;
    en_def = 1'b1;
    hits = 0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      #1;
      if (i < 65534 && lfsr_state_def == 16'd42) hits++;
    end
    check("def_no_early_repeat", hits, 0);
    check("def_period_back_to_seed", lfsr_state_def, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
